zcu216_mmcm_lock_sequencer: RTL

//  Controller at the far end of the PL clock MMCM. Drives the MMCM RST pin and consumes its asynchronous

---
 rtl/zcu216_mmcm_lock_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/zcu216_mmcm_lock_sequencer.sv
// MMCM reset/lock sequencer: pulses MMCM RST, debounces LOCKED, and releases the adc_clk user reset.
// Retries on lock timeout and keeps saturating lock-loss and timeout event counters.
module zcu216_mmcm_lock_sequencer #(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned STABLE_CYCLES       = 1024,
  parameter int unsigned CNT_W               = 16
) (
  input  logic             pl_clk_i,
  input  logic             pl_rst_ni,
  input  logic             mmcm_locked_i,
  input  logic             force_reset_i,
  input  logic             clr_counts_i,
  output logic             mmcm_rst_o,
  output logic             adc_rst_o,
  output logic             lock_stable_o,
  output logic [CNT_W-1:0] lock_loss_count_o,
  output logic [CNT_W-1:0] timeout_count_o,
  output logic [1:0]       state_o
);

  localparam logic [1:0] StReset  = 2'd0;
  localparam logic [1:0] StWait   = 2'd1;
  localparam logic [1:0] StStable = 2'd2;
  localparam logic [1:0] StRun    = 2'd3;

  localparam int unsigned MaxA   = (RST_PULSE_CYCLES > STABLE_CYCLES) ? RST_PULSE_CYCLES
                                                                      : STABLE_CYCLES;
  localparam int unsigned TmrMax = (MaxA > LOCK_TIMEOUT_CYCLES) ? MaxA : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned TmrW   = $clog2(TmrMax) + 1;

  localparam logic [TmrW-1:0] RstLast    = TmrW'(RST_PULSE_CYCLES - 1);
  localparam logic [TmrW-1:0] TmoLast    = TmrW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TmrW-1:0] StableLast = TmrW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic [1:0]             state_q, state_d;
  logic [TmrW-1:0]        timer_q, timer_d;
  logic [CNT_W-1:0]       loss_q, loss_d, tmo_q, tmo_d;
  logic                   loss_inc, tmo_inc;
  logic                   mmcm_rst_q, adc_rst_q, lock_stable_q;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + TmrW'(1);
    loss_inc = 1'b0;
    tmo_inc  = 1'b0;
    unique case (state_q)
      StReset: begin
        if (timer_q == RstLast) begin
          state_d = StWait;
          timer_d = '0;
        end
      end
      StWait: begin
        // Lock takes priority over a coincident timeout.
        if (locked_s) begin
          state_d = StStable;
          timer_d = '0;
        end else if (timer_q == TmoLast) begin
          state_d = StReset;
          timer_d = '0;
          tmo_inc = 1'b1;
        end
      end
      StStable: begin
        if (!locked_s) begin
          state_d = StWait;
          timer_d = '0;
        end else if (timer_q == StableLast) begin
          state_d = StRun;
          timer_d = '0;
        end
      end
      StRun: begin
        timer_d = '0;
        if (!locked_s) begin
          state_d  = StReset;
          loss_inc = 1'b1;
        end
      end
      default: begin
        state_d = StReset;
        timer_d = '0;
      end
    endcase
    // A forced restart still records a lock drop seen in the same cycle.
    if (force_reset_i) begin
      state_d = StReset;
      timer_d = '0;
      tmo_inc = 1'b0;
    end
  end

  always_comb begin
    loss_d = loss_q;
    tmo_d  = tmo_q;
    if (clr_counts_i) begin
      loss_d = '0;
      tmo_d  = '0;
    end
    if (loss_inc) begin
      loss_d = clr_counts_i ? CNT_W'(1) : ((&loss_q) ? loss_q : loss_q + CNT_W'(1));
    end
    if (tmo_inc) begin
      tmo_d = clr_counts_i ? CNT_W'(1) : ((&tmo_q) ? tmo_q : tmo_q + CNT_W'(1));
    end
  end

  always_ff @(posedge pl_clk_i or negedge pl_rst_ni) begin
    if (!pl_rst_ni) begin
      sync_q        <= '0;
      state_q       <= StReset;
      timer_q       <= '0;
      loss_q        <= '0;
      tmo_q         <= '0;
      mmcm_rst_q    <= 1'b1;
      adc_rst_q     <= 1'b1;
      lock_stable_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], mmcm_locked_i};
      state_q       <= state_d;
      timer_q       <= timer_d;
      loss_q        <= loss_d;
      tmo_q         <= tmo_d;
      mmcm_rst_q    <= (state_d == StReset);
      adc_rst_q     <= (state_d != StRun);
      lock_stable_q <= (state_d == StRun);
    end
  end

  assign mmcm_rst_o        = mmcm_rst_q;
  assign adc_rst_o         = adc_rst_q;
  assign lock_stable_o     = lock_stable_q;
  assign lock_loss_count_o = loss_q;
  assign timeout_count_o   = tmo_q;
  assign state_o           = state_q;

endmodule
